rf_wr_buf: RTL and testbench

Write-back buffer that is the requesting side of the 8x16 register file's single write port. It accepts register write requests from the pipeline writeback stage with a valid/ready handshake, queues them in order, and drains them one per cycle into the register file (`writeregsel`/`writedata`/`write`). It also provides a two-port forwarding lookup so decode can read values still queued and not yet visible in the register file.

---
 rtl/rf_pkg.sv | 7 +
 rtl/wrbuf_ptr.sv | 25 ++
 rtl/rf_wr_buf.sv | 111 +++++++++++
 tb/tb_rf_wr_buf.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants for the write-back path.
package rf_pkg;
  localparam int unsigned DW       = 16;
  localparam int unsigned AW       = 3;
  localparam int unsigned NREGS    = 8;
  localparam int unsigned WB_DEPTH = 4;
endpackage

// File: rtl/wrbuf_ptr.sv
// Wrapping queue pointer: W-bit counter, synchronous reset, increment enable.
module wrbuf_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer; wraps naturally at 2^W.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/rf_wr_buf.sv
// Write-back buffer: in-order queue feeding the register file write port,
// with two combinational forwarding lookups over the queued entries.
module rf_wr_buf
  import rf_pkg::*;
#(
  parameter int unsigned DW    = rf_pkg::DW,
  parameter int unsigned AW    = rf_pkg::AW,
  parameter int unsigned DEPTH = rf_pkg::WB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_reg,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          rf_stall,
  output logic [AW-1:0] writeregsel,
  output logic [DW-1:0] writedata,
  output logic          write,
  input  logic [AW-1:0] lk1_sel,
  input  logic [AW-1:0] lk2_sel,
  output logic          lk1_hit,
  output logic          lk2_hit,
  output logic [DW-1:0] lk1_data,
  output logic [DW-1:0] lk2_data,
  output logic          err
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] sel_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          push, pop;

  // Handshake and drain qualifiers; both forced low during reset.
  always_comb begin
    in_ready = !rst && (count_q < CW'(DEPTH));
    write    = !rst && (count_q != '0) && !rf_stall;
    push     = in_valid && in_ready;
    pop      = write;
  end

  wrbuf_ptr #(.W(PW)) u_head (.clk(clk), .rst(rst), .inc_i(pop),  .ptr_o(head_q));
  wrbuf_ptr #(.W(PW)) u_tail (.clk(clk), .rst(rst), .inc_i(push), .ptr_o(tail_q));

  // Occupancy and sticky overflow next-state.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q || (in_valid && !in_ready);
  end

  // Occupancy and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage, written only at the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (push && (tail_q == PW'(k))) begin
        sel_q[k] <= in_reg;
        dat_q[k] <= in_data;
      end
    end
  end

  // Head entry drives the register file port; held while not popped.
  always_comb begin
    writeregsel = sel_q[head_q];
    writedata   = dat_q[head_q];
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    lk1_hit  = 1'b0;
    lk2_hit  = 1'b0;
    lk1_data = '0;
    lk2_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (sel_q[idx] == lk1_sel) begin
          lk1_hit  = 1'b1;
          lk1_data = dat_q[idx];
        end
        if (sel_q[idx] == lk2_sel) begin
          lk2_hit  = 1'b1;
          lk2_data = dat_q[idx];
        end
      end
    end
  end

  assign err = err_q;
endmodule

// File: tb/tb_rf_wr_buf.sv
// Self-checking bench for rf_wr_buf against a queue-based reference model.
module tb_rf_wr_buf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_reg = '0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        rf_stall = 1'b0;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [2:0]  lk1_sel = '0, lk2_sel = '0;
  logic        lk1_hit, lk2_hit;
  logic [15:0] lk1_data, lk2_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [2:0] r; logic [15:0] d; } ent_t;
  ent_t mq[$];
  bit   err_m = 1'b0;

  always #5 clk = ~clk;

  rf_wr_buf #(.DW(16), .AW(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .rf_stall(rf_stall), .writeregsel(writeregsel),
    .writedata(writedata), .write(write), .lk1_sel(lk1_sel), .lk2_sel(lk2_sel),
    .lk1_hit(lk1_hit), .lk2_hit(lk2_hit), .lk1_data(lk1_data), .lk2_data(lk2_data),
    .err(err)
  );

  // Reference model: a FIFO of pending writes.
  function automatic bit m_ready();
    return !rst && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_write();
    return !rst && (mq.size() != 0) && !rf_stall;
  endfunction

  function automatic void m_lookup(input logic [2:0] sel, output bit hit, output logic [15:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (mq[i]) if (mq[i].r == sel) begin hit = 1'b1; d = mq[i].d; end
  endfunction

  // Advance one clock edge, updating the model from the applied inputs.
  task automatic tick();
    bit rdy, wr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      err_m = 1'b0;
    end else begin
      rdy = mq.size() < DEPTH;
      wr  = (mq.size() != 0) && !rf_stall;
      if (in_valid && !rdy) err_m = 1'b1;
      if (wr) void'(mq.pop_front());
      if (in_valid && rdy) mq.push_back('{r: in_reg, d: in_data});
    end
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rf_stall = 1'b0;
    for (int i = 0; i < 20 && mq.size() != 0; i++) tick();
    n_cmp++;
    if (mq.size() != 0) begin n_bad++; $display("FAIL drain_timeout: left=%0d want 0", mq.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL rst_write: got %b want 0", write); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0; lk1_sel = 3'd0; lk2_sel = 3'd5; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL post_rst_write: got %b want 0", write); end
    n_cmp++; if ({lk1_hit, lk2_hit} !== 2'b00) begin n_bad++; $display("FAIL post_rst_hits: got %b want 00", {lk1_hit, lk2_hit}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL post_rst_err: got %b want 0", err); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_reg = 3'd3; in_data = 16'h1234; lk1_sel = 3'd3; #1;
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL single_write: got %b want 1", write); end
    n_cmp++; if (writeregsel !== 3'd3) begin n_bad++; $display("FAIL single_sel: got %0d want 3", writeregsel); end
    n_cmp++; if (writedata !== 16'h1234) begin n_bad++; $display("FAIL single_data: got %h want 1234", writedata); end
    n_cmp++; if (lk1_hit !== 1'b1 || lk1_data !== 16'h1234) begin n_bad++; $display("FAIL single_fwd: got %b/%h want 1/1234", lk1_hit, lk1_data); end
    tick(); #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", write); end
    n_cmp++; if (lk1_hit !== 1'b0) begin n_bad++; $display("FAIL single_nohit: got %b want 0", lk1_hit); end
  endtask

  task automatic test_stall();
    logic [2:0]  rs[4] = '{3'd1, 3'd2, 3'd1, 3'd5};
    logic [15:0] ds[4] = '{16'h0001, 16'h0002, 16'h00FF, 16'h5555};
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = rs[i]; in_data = ds[i]; #1;
      n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL stall_write%0d: got %b want 0", i, write); end
      tick();
    end
    in_valid = 1'b0; lk1_sel = 3'd1; lk2_sel = 3'd4; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_full: got %b want 0", in_ready); end
    n_cmp++; if (lk1_hit !== 1'b1 || lk1_data !== 16'h00FF) begin n_bad++; $display("FAIL stall_fwd1: got %b/%h want 1/00ff", lk1_hit, lk1_data); end
    n_cmp++; if (lk2_hit !== 1'b0 || lk2_data !== 16'h0000) begin n_bad++; $display("FAIL stall_fwd_miss: got %b/%h want 0/0000", lk2_hit, lk2_data); end
    in_valid = 1'b1; in_reg = 3'd7; in_data = 16'hDEAD; #1;
    tick();
    in_valid = 1'b0; #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL overflow_err: got %b want 1", err); end
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (write !== 1'b1 || writeregsel !== rs[i] || writedata !== ds[i]) begin
        n_bad++; $display("FAIL drain%0d: got %b/%0d/%h want 1/%0d/%h", i, write, writeregsel, writedata, rs[i], ds[i]);
      end
      tick();
    end
    #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", write); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_full_nostall();
    rf_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_reg = 3'($urandom); in_data = 16'($urandom); tick();
    end
    rf_stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_reg = 3'($urandom); in_data = 16'($urandom); #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, m_ready()); end
      n_cmp++;
      if (write !== m_write() || writeregsel !== mq[0].r || writedata !== mq[0].d) begin
        n_bad++; $display("FAIL full_head%0d: got %b/%0d/%h want %b/%0d/%h", i, write, writeregsel, writedata, m_write(), mq[0].r, mq[0].d);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    rf_stall = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      in_valid = (i < 10); in_reg = 3'(i % 8); in_data = 16'hA000 + 16'(i); #1;
      if (i == 0) begin
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL wrap_first: got %b want 0", write); end
      end else begin
        n_cmp++;
        if (write !== 1'b1 || writeregsel !== 3'((i - 1) % 8) || writedata !== 16'hA000 + 16'(i - 1)) begin
          n_bad++; $display("FAIL wrap%0d: got %b/%0d/%h want 1/%0d/%h", i, write, writeregsel, writedata, (i - 1) % 8, 16'hA000 + 16'(i - 1));
        end
      end
      tick();
    end
    in_valid = 1'b0; #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL wrap_end: got %b want 0", write); end
  endtask

  task automatic test_mid_reset();
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 3'(i + 2); in_data = 16'h0B00 + 16'(i); tick();
    end
    // fourth push overflowed nothing (depth 4); force an overflow to set err
    in_valid = 1'b1; tick();
    rf_stall = 1'b0; in_valid = 1'b0; tick(); // one pop: 3 entries remain
    rst = 1'b1; lk1_sel = 3'd3; #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL midrst_write: got %b want 0", write); end
    tick();
    rst = 1'b0; #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL midrst_after_write: got %b want 0", write); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", err); end
    n_cmp++; if (lk1_hit !== 1'b0) begin n_bad++; $display("FAIL midrst_hit: got %b want 0", lk1_hit); end
    tick(); #1;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL midrst_nowrite: got %b want 0", write); end
  endtask

  task automatic test_random();
    bit h1, h2;
    logic [15:0] d1, d2;
    for (int i = 0; i < 500; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      rf_stall = ($urandom_range(0, 2) == 0);
      in_reg   = 3'($urandom);
      in_data  = 16'($urandom);
      lk1_sel  = 3'($urandom);
      lk2_sel  = 3'($urandom);
      #1;
      m_lookup(lk1_sel, h1, d1);
      m_lookup(lk2_sel, h2, d2);
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", i, in_ready, m_ready()); end
      n_cmp++; if (write !== m_write()) begin n_bad++; $display("FAIL rnd_write@%0d: got %b want %b", i, write, m_write()); end
      if (mq.size() != 0) begin
        n_cmp++;
        if (writeregsel !== mq[0].r || writedata !== mq[0].d) begin
          n_bad++; $display("FAIL rnd_head@%0d: got %0d/%h want %0d/%h", i, writeregsel, writedata, mq[0].r, mq[0].d);
        end
      end
      n_cmp++; if (lk1_hit !== h1 || lk1_data !== d1) begin n_bad++; $display("FAIL rnd_lk1@%0d: got %b/%h want %b/%h", i, lk1_hit, lk1_data, h1, d1); end
      n_cmp++; if (lk2_hit !== h2 || lk2_data !== d2) begin n_bad++; $display("FAIL rnd_lk2@%0d: got %b/%h want %b/%h", i, lk2_hit, lk2_data, h2, d2); end
      n_cmp++; if (err !== err_m) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", i, err, err_m); end
      tick();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_full_nostall();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
